// File: rtl/alu_writeback.sv
// alu_writeback: buffers registered ALU results in a small FIFO and retires
// them in order, either as register-file writes (ready handshake) or as
// resolved branches. Retirement updates the architectural Z/N/V flags.
//
// Optional feature macro: ALU_WB_OVF_TRAP_EN
//   defined   -> a write-kind result with overflow is dropped and raises a
//                sticky trap that blocks the pipe until trap_clr.
//   undefined -> overflow only sets flag_v; trap is tied low.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   ALU result handshake (in_data, in_ovf, in_rd, in_kind)
//   wr_en/wr_ready      register-file write handshake (wr_addr, wr_data)
//   br_valid, br_taken  branch resolution of the head entry
//   flag_z/n/v          flags of the last retired entry
//   trap, trap_clr      sticky overflow trap and its clear
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_ovf,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [1:0]        in_kind,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              br_valid,
  output logic              br_taken,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  output logic              trap,
  input  logic              trap_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] KIND_WR  = 2'b00;
  localparam logic [1:0] KIND_BZ  = 2'b01;
  localparam logic [1:0] KIND_BNZ = 2'b10;
  localparam logic [1:0] KIND_BN  = 2'b11;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_ovf  [DEPTH];
  logic [ADDR_W-1:0] mem_rd   [DEPTH];
  logic [1:0]        mem_kind [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             trap_q;

  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic              head_ovf;
  logic [ADDR_W-1:0] head_rd;
  logic [1:0]        head_kind;
  logic              head_z;
  logic              head_n;
  logic              head_is_wr;
  logic              trap_hit;
  logic              push;
  logic              retire;

  assign head_data  = mem_data[rd_ptr];
  assign head_ovf   = mem_ovf[rd_ptr];
  assign head_rd    = mem_rd[rd_ptr];
  assign head_kind  = mem_kind[rd_ptr];
  assign head_z     = (head_data == '0);
  assign head_n     = head_data[DATA_W-1];
  assign head_is_wr = (head_kind == KIND_WR);

`ifdef ALU_WB_OVF_TRAP_EN
  // A pending trap freezes both ends of the FIFO until software clears it.
  assign head_valid = (count != '0) && !trap_q;
  assign in_ready   = (count != CNT_W'(DEPTH)) && !trap_q;
  assign trap_hit   = head_valid && head_is_wr && head_ovf;
  assign trap       = trap_q;
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr;
  assign head_valid = (count != '0);
  assign in_ready   = (count != CNT_W'(DEPTH));
  assign trap_hit   = 1'b0;
  assign trap       = 1'b0;
`endif

  assign push = in_valid && in_ready;

  // rd=0 writes and trapped overflow writes are dropped but still retire.
  assign wr_en   = head_valid && head_is_wr && (head_rd != '0) && !trap_hit;
  assign wr_addr = head_rd;
  assign wr_data = head_data;
  assign retire  = head_valid && (!head_is_wr || !wr_en || wr_ready);

  assign br_valid = head_valid && !head_is_wr;

  always_comb begin
    br_taken = 1'b0;
    if (br_valid) begin
      case (head_kind)
        KIND_BZ:  br_taken = head_z;
        KIND_BNZ: br_taken = !head_z;
        KIND_BN:  br_taken = head_n;
        default:  br_taken = 1'b0;
      endcase
    end
  end

  // Payload storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_ovf[wr_ptr]  <= in_ovf;
      mem_rd[wr_ptr]   <= in_rd;
      mem_kind[wr_ptr] <= in_kind;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (retire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (retire) begin
        flag_z <= head_z;
        flag_n <= head_n;
        flag_v <= head_ovf;
      end
      // Clear wins over a same-cycle set.
      if (trap_clr)      trap_q <= 1'b0;
      else if (trap_hit) trap_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_ovf;
  logic [4:0]  in_rd;
  logic [1:0]  in_kind;
  logic        wr_en;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        br_valid;
  logic        br_taken;
  logic        flag_z, flag_n, flag_v;
  logic        trap;
  logic        trap_clr;

  alu_writeback #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ovf(in_ovf), .in_rd(in_rd), .in_kind(in_kind),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .br_valid(br_valid), .br_taken(br_taken),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .trap(trap), .trap_clr(trap_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic [4:0]  rd;
    logic [1:0]  kind;
    logic        e_wr;
    logic        e_br;
    logic        e_tk;
    logic        e_z;
    logic        e_n;
    logic        e_v;
  } vec_t;

  typedef struct {
    logic        is_br;
    logic        tk;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[10];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic o, input logic [4:0] r,
                       input logic [1:0] k);
    in_valid = 1'b1;
    in_data  = d;
    in_ovf   = o;
    in_rd    = r;
    in_kind  = k;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.is_br = 1'b0; e.tk = 1'b0; e.addr = a; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic expect_br(input logic tk);
    exp_t e;
    e.is_br = 1'b1; e.tk = tk; e.addr = '0; e.data = '0;
    sbq.push_back(e);
  endtask

  // Scoreboard: every accepted write or resolved branch pops one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ((wr_en && wr_ready) || br_valid)) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got wr_en=%0b br_valid=%0b expected no output",
                 wr_en, br_valid);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_is_branch", br_valid, e.is_br);
        if (e.is_br) begin
          chk("sb_taken", br_taken, e.tk);
        end else begin
          chk("sb_addr", wr_addr, e.addr);
          chk("sb_data", wr_data, e.data);
        end
      end
    end
  end

  initial begin
    //           data          ovf  rd     kind   wr br tk z  n  v
    vecs[0] = '{32'd5,         1'b0, 5'd3,  2'b00, 1, 0, 0, 0, 0, 0};
    vecs[1] = '{32'd0,         1'b0, 5'd1,  2'b00, 1, 0, 0, 1, 0, 0};
    vecs[2] = '{32'd3,         1'b0, 5'd0,  2'b01, 0, 1, 0, 0, 0, 0};
    vecs[3] = '{32'd0,         1'b0, 5'd0,  2'b01, 0, 1, 1, 1, 0, 0};
    vecs[4] = '{32'd9,         1'b0, 5'd0,  2'b10, 0, 1, 1, 0, 0, 0};
    vecs[5] = '{32'd0,         1'b0, 5'd0,  2'b10, 0, 1, 0, 1, 0, 0};
    vecs[6] = '{32'h7FFFFFFF,  1'b0, 5'd0,  2'b11, 0, 1, 0, 0, 0, 0};
    vecs[7] = '{32'hFFFFFFFF,  1'b1, 5'd0,  2'b11, 0, 1, 1, 0, 1, 1};
    vecs[8] = '{32'd7,         1'b0, 5'd0,  2'b00, 0, 0, 0, 0, 0, 0};
    vecs[9] = '{32'h12345678,  1'b0, 5'd31, 2'b00, 1, 0, 0, 0, 0, 0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_ovf   = 1'b0;
    in_rd    = '0;
    in_kind  = '0;
    wr_ready = 1'b1;
    trap_clr = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_br_valid", br_valid, 0);
    chk("rst_flags", {flag_z, flag_n, flag_v}, 0);
    chk("rst_trap", trap, 0);
    rst_n = 1'b1;
    tick();

    // Single-entry vectors through an empty FIFO with wr_ready held high.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].data, vecs[i].ovf, vecs[i].rd, vecs[i].kind);
      if (vecs[i].e_wr) expect_wr(vecs[i].rd, vecs[i].data);
      if (vecs[i].e_br) expect_br(vecs[i].e_tk);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_wr_en", i), wr_en, vecs[i].e_wr);
      chk($sformatf("v%0d_br_valid", i), br_valid, vecs[i].e_br);
      chk($sformatf("v%0d_br_taken", i), br_taken, vecs[i].e_tk);
      tick();
      chk($sformatf("v%0d_flags", i), {flag_z, flag_n, flag_v},
          {vecs[i].e_z, vecs[i].e_n, vecs[i].e_v});
      chk($sformatf("v%0d_drained", i), wr_en | br_valid, 0);
    end

    // Backpressure: three writes against a stalled register file.
    wr_ready = 1'b0;
    drive(32'd100, 1'b0, 5'd10, 2'b00); expect_wr(5'd10, 32'd100);
    tick();
    chk("bp_ready_1", in_ready, 1);
    drive(32'd101, 1'b0, 5'd11, 2'b00); expect_wr(5'd11, 32'd101);
    tick();
    chk("bp_full", in_ready, 0);
    chk("bp_hold_en", wr_en, 1);
    chk("bp_hold_addr", wr_addr, 10);
    drive(32'd102, 1'b0, 5'd12, 2'b00);
    tick();
    chk("bp_still_full", in_ready, 0);
    chk("bp_stable_addr", wr_addr, 10);
    chk("bp_stable_data", wr_data, 100);
    wr_ready = 1'b1;
    tick();
    chk("bp_ready_after_pop", in_ready, 1);
    chk("bp_second_addr", wr_addr, 11);
    expect_wr(5'd12, 32'd102);
    tick();
    in_valid = 1'b0;
    chk("bp_third_addr", wr_addr, 12);
    chk("bp_third_en", wr_en, 1);
    tick();
    chk("bp_empty", wr_en, 0);

    // Back-to-back branches.
    drive(32'd0, 1'b0, 5'd0, 2'b01); expect_br(1'b1);
    tick();
    drive(32'h80000000, 1'b0, 5'd0, 2'b11); expect_br(1'b1);
    chk("br1_taken", br_taken, 1);
    chk("br1_wr_en", wr_en, 0);
    tick();
    in_valid = 1'b0;
    chk("br2_taken", br_taken, 1);
    chk("br2_wr_en", wr_en, 0);
    tick();
    chk("br_flag_n", flag_n, 1);
    chk("br_flag_z", flag_z, 0);

    // Overflowing write.
    drive(32'h80000000, 1'b1, 5'd4, 2'b00);
`ifdef ALU_WB_OVF_TRAP_EN
    tick();
    in_valid = 1'b0;
    chk("ovf_no_write", wr_en, 0);
    tick();
    chk("ovf_trap_set", trap, 1);
    chk("ovf_trap_blocks", in_ready, 0);
    chk("ovf_flag_v", flag_v, 1);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    chk("ovf_trap_clr", trap, 0);
    chk("ovf_ready_again", in_ready, 1);
`else
    expect_wr(5'd4, 32'h80000000);
    tick();
    in_valid = 1'b0;
    chk("ovf_write", wr_en, 1);
    tick();
    chk("ovf_flag_v", flag_v, 1);
    chk("ovf_trap_tied", trap, 0);
`endif

    // Reset with two entries queued behind a stalled register file.
    wr_ready = 1'b0;
    drive(32'd55, 1'b0, 5'd5, 2'b00);
    tick();
    drive(32'd66, 1'b0, 5'd6, 2'b00);
    tick();
    in_valid = 1'b0;
    chk("mr_full", in_ready, 0);
    rst_n = 1'b0;
    sbq.delete();
    tick();
    chk("mr_wr_en", wr_en, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_flags", {flag_z, flag_n, flag_v}, 0);
    chk("mr_trap", trap, 0);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    tick();
    chk("mr_discarded", wr_en | br_valid, 0);
    tick();
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
